// File: rtl/fx1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fx1_pkg
//  Description : Shared constants, FX1 unit-local op codes and the
//                op-legality helper used by the FX1 issue controller.
//  Revision    : 1.0  initial release
// ============================================================================
package fx1_pkg;

  localparam int FX1_OP_W   = 4;
  localparam int FX1_REG_AW = 7;
  localparam int FX1_DATA_W = 128;
  localparam int FX1_IMM_W  = 10;
  localparam int FX1_CNT_W  = 32;

  // Code 4'hF is deliberately left unassigned; it reaches the unit only
  // through a decode error and is reported as an exception.
  typedef enum logic [FX1_OP_W-1:0] {
    FX1_AND   = 4'h0,
    FX1_ANDC  = 4'h1,
    FX1_ANDBI = 4'h2,
    FX1_ANDHI = 4'h3,
    FX1_ANDI  = 4'h4,
    FX1_OR    = 4'h5,
    FX1_ORBI  = 4'h6,
    FX1_ORHI  = 4'h7,
    FX1_ORI   = 4'h8,
    FX1_XOR   = 4'h9,
    FX1_XORBI = 4'hA,
    FX1_XORHI = 4'hB,
    FX1_XORI  = 4'hC,
    FX1_NAND  = 4'hD,
    FX1_NOR   = 4'hE
  } fx1_op_e;

  function automatic logic fx1_op_supported(input logic [FX1_OP_W-1:0] op);
    logic ok;
    case (op)
      FX1_AND, FX1_ANDC, FX1_ANDBI, FX1_ANDHI, FX1_ANDI,
      FX1_OR,  FX1_ORBI, FX1_ORHI,  FX1_ORI,
      FX1_XOR, FX1_XORBI, FX1_XORHI, FX1_XORI,
      FX1_NAND, FX1_NOR:                 ok = 1'b1;
      default:                           ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fx1_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fx1_pipe_stage
//  Description : One valid/data pipeline register. Loads when advancing,
//                holds while stalled, drops its valid on flush.
//  Revision    : 1.0  initial release
//  Ports       : clk, reset      clock / synchronous active-high reset
//                flush_i         clear valid at next edge
//                adv_i           stage may take new contents this cycle
//                vld_i, data_i   incoming entry
//                vld_o, data_o   registered entry
// ============================================================================
module fx1_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         adv_i,
  input  logic         vld_i,
  input  logic [W-1:0] data_i,
  output logic         vld_o,
  output logic [W-1:0] data_o
);

  logic         vld_q, vld_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (flush_i) begin
      vld_d = 1'b0;
    end else if (adv_i) begin
      vld_d = vld_i;
      // Data only moves with a real entry so bubbles do not toggle the bus.
      if (vld_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/fx1_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fx1_issue_ctrl
//  Description : Issue/sequencing controller for the FX1 fixed-point unit.
//                EX1 holds the issued op and drives the combinational
//                datapath; EX2 captures the result and presents it to the
//                register-file writeback port with backpressure.
//  Revision    : 1.0  initial release
//  Ports       : clk, reset        clock / synchronous active-high reset
//                flush             kill all in-flight ops
//                in_*              issue handshake and decoded op
//                dp_*              operands/op to datapath, dp_result back
//                wb_*              writeback request with backpressure
//                ex1_*/ex2_*       stage occupancy and targets (scoreboard)
//                busy, retired     activity flag, completed-writeback count
//  Note        : operand buses use bit 0 = MSB naming in the ISA; the
//                controller only passes them through, so packing is opaque.
// ============================================================================
module fx1_issue_ctrl
  import fx1_pkg::*;
#(
  parameter int DATA_W = FX1_DATA_W,
  parameter int REG_AW = FX1_REG_AW,
  parameter int OP_W   = FX1_OP_W,
  parameter int IMM_W  = FX1_IMM_W,
  parameter int CNT_W  = FX1_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [DATA_W-1:0] in_ra,
  input  logic [DATA_W-1:0] in_rb,
  input  logic [IMM_W-1:0]  in_imm,
  output logic [OP_W-1:0]   dp_op,
  output logic [DATA_W-1:0] dp_ra,
  output logic [DATA_W-1:0] dp_rb,
  output logic [IMM_W-1:0]  dp_imm,
  input  logic [DATA_W-1:0] dp_result,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_rt,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_exc,
  output logic              ex1_vld,
  output logic              ex2_vld,
  output logic [REG_AW-1:0] ex1_rt,
  output logic [REG_AW-1:0] ex2_rt,
  output logic              busy,
  output logic [CNT_W-1:0]  retired
);

  localparam int EX1_W = OP_W + REG_AW + 2 * DATA_W + IMM_W;
  localparam int EX2_W = 1 + REG_AW + DATA_W;

  logic              ex1_adv, ex2_adv;
  logic              ex1_load;
  logic [EX1_W-1:0]  ex1_din, ex1_q;
  logic [EX2_W-1:0]  ex2_din, ex2_q;
  logic              ex1_op_ok;
  logic [DATA_W-1:0] ex2_data_in;
  logic [CNT_W-1:0]  retired_q, retired_d;

  // A stage may move when it is empty or its successor moves. EX1 therefore
  // absorbs one bubble behind a stalled EX2 before in_ready drops.
  assign ex2_adv  = !ex2_vld || wb_ready;
  assign ex1_adv  = !ex1_vld || ex2_adv;
  assign in_ready = ex1_adv && !flush && !reset;
  assign ex1_load = in_valid && in_ready;

  assign ex1_din = {in_op, in_rt, in_ra, in_rb, in_imm};

  fx1_pipe_stage #(.W(EX1_W)) u_ex1 (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .adv_i   (ex1_adv),
    .vld_i   (ex1_load),
    .data_i  (ex1_din),
    .vld_o   (ex1_vld),
    .data_o  (ex1_q)
  );

  assign {dp_op, ex1_rt, dp_ra, dp_rb, dp_imm} = ex1_q;

  // Illegal op codes still occupy a slot and retire, but write zero and
  // flag the exception so the register file never sees garbage.
  assign ex1_op_ok   = fx1_op_supported(dp_op);
  assign ex2_data_in = ex1_op_ok ? dp_result : '0;
  assign ex2_din     = {!ex1_op_ok, ex1_rt, ex2_data_in};

  fx1_pipe_stage #(.W(EX2_W)) u_ex2 (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .adv_i   (ex2_adv),
    .vld_i   (ex1_vld),
    .data_i  (ex2_din),
    .vld_o   (ex2_vld),
    .data_o  (ex2_q)
  );

  assign {wb_exc, wb_rt, wb_data} = ex2_q;
  assign wb_valid = ex2_vld;
  assign ex2_rt   = wb_rt;
  assign busy     = ex1_vld || ex2_vld;

  // A writeback accepted in a flush cycle has already landed in the
  // register file, so it still counts.
  always_comb begin
    retired_d = retired_q;
    if (wb_valid && wb_ready) retired_d = retired_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_fx1_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fx1_issue_ctrl
//  Description : Self-checking bench for fx1_issue_ctrl. A queue-based model
//                tracks accepted ops as a 2-deep FIFO with 2-cycle latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fx1_issue_ctrl;
  import fx1_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1, flush = 1'b0, in_valid = 1'b0, wb_ready = 1'b1;
  logic [3:0]   in_op = '0;
  logic [6:0]   in_rt = '0;
  logic [127:0] in_ra = '0, in_rb = '0;
  logic [9:0]   in_imm = '0;
  logic         in_ready, wb_valid, wb_exc, ex1_vld, ex2_vld, busy;
  logic [3:0]   dp_op;
  logic [127:0] dp_ra, dp_rb, dp_result, wb_data;
  logic [9:0]   dp_imm;
  logic [6:0]   wb_rt, ex1_rt, ex2_rt;
  logic [31:0]  retired;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Stand-in datapath: any function of all four inputs, so a wrong operand
  // routed to dp_* corrupts the expected writeback data.
  function automatic logic [127:0] dp_fn(input logic [3:0] op, input logic [127:0] a,
                                         input logic [127:0] b, input logic [9:0] imm);
    return a ^ {b[63:0], b[127:64]} ^ {118'b0, imm} ^ ({124'b0, op} << 100);
  endfunction

  assign dp_result = dp_fn(dp_op, dp_ra, dp_rb, dp_imm);

  fx1_issue_ctrl dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rt(in_rt), .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm),
    .dp_op(dp_op), .dp_ra(dp_ra), .dp_rb(dp_rb), .dp_imm(dp_imm), .dp_result(dp_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rt(wb_rt), .wb_data(wb_data), .wb_exc(wb_exc),
    .ex1_vld(ex1_vld), .ex2_vld(ex2_vld), .ex1_rt(ex1_rt), .ex2_rt(ex2_rt),
    .busy(busy), .retired(retired)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [6:0]   rt;
    logic [127:0] data;
    logic         exc;
    int           acc;
  } ent_t;

  ent_t        q[$];
  int          cyc = 0;
  logic [31:0] exp_retired = '0;

  function automatic bit exp_wb_valid();
    return (q.size() > 0) && (cyc >= q[0].acc + 2);
  endfunction

  function automatic bit exp_in_ready();
    return !reset && !flush && ((q.size() < 2) || wb_ready);
  endfunction

  function automatic bit exp_ex1();
    return (q.size() == 2) || ((q.size() == 1) && !exp_wb_valid());
  endfunction

  function automatic logic [127:0] exp_data(input logic [3:0] op, input logic [127:0] a,
                                            input logic [127:0] b, input logic [9:0] imm);
    return (op == 4'hF) ? 128'b0 : dp_fn(op, a, b, imm);
  endfunction

  // Advance one clock: evaluate the handshake with current inputs, update
  // the model at the edge, and return at the following falling edge.
  task automatic tick();
    bit   acc, fire;
    ent_t e;
    acc  = in_valid && exp_in_ready();
    fire = exp_wb_valid() && wb_ready;
    e.rt   = in_rt;
    e.data = exp_data(in_op, in_ra, in_rb, in_imm);
    e.exc  = (in_op == 4'hF);
    e.acc  = cyc;
    @(posedge clk);
    if (reset) begin
      q.delete();
      exp_retired = '0;
    end else begin
      if (fire) begin
        void'(q.pop_front());
        exp_retired = exp_retired + 1;
      end
      if (flush) q.delete();
      else if (acc) q.push_back(e);
    end
    cyc++;
    @(negedge clk);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_ready = 1'b1;
    tick(); tick();
    #1;
    checks++; if (ex1_vld !== 1'b0) begin errors++; $display("FAIL reset_ex1_vld got %0h exp 0", ex1_vld); end
    checks++; if (ex2_vld !== 1'b0) begin errors++; $display("FAIL reset_ex2_vld got %0h exp 0", ex2_vld); end
    checks++; if (wb_exc !== 1'b0) begin errors++; $display("FAIL reset_wb_exc got %0h exp 0", wb_exc); end
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired got %0h exp 0", retired); end
    checks++; if (dp_op !== 4'd0 || dp_ra !== 128'd0 || dp_imm !== 10'd0) begin errors++; $display("FAIL reset_dp got op=%0h ra=%0h imm=%0h exp 0", dp_op, dp_ra, dp_imm); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0h exp 0", in_ready); end
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %0h exp 1", in_ready); end
    tick();
  endtask

  task automatic test_single();
    logic [127:0] rb, ed;
    logic [31:0]  r0;
    r0 = exp_retired; rb = rnd128();
    ed = dp_fn(FX1_ANDHI, {128{1'b1}}, rb, 10'h3FF);
    in_valid = 1'b1; in_op = FX1_ANDHI; in_rt = 7'd5; in_ra = {128{1'b1}}; in_rb = rb; in_imm = 10'h3FF;
    wb_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got %0h exp 1", in_ready); end
    tick();
    in_valid = 1'b0; in_op = '0; in_ra = '0; in_rb = '0; in_imm = '0;
    #1;
    checks++; if (ex1_vld !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL single_n1_valid got ex1=%0h wb=%0h exp 1/0", ex1_vld, wb_valid); end
    checks++; if (dp_op !== FX1_ANDHI || dp_imm !== 10'h3FF || ex1_rt !== 7'd5) begin errors++; $display("FAIL single_n1_dp got op=%0h imm=%0h rt=%0d exp 3/3ff/5", dp_op, dp_imm, ex1_rt); end
    tick();
    #1;
    checks++; if (wb_valid !== 1'b1 || wb_rt !== 7'd5 || wb_exc !== 1'b0) begin errors++; $display("FAIL single_n2_wb got v=%0h rt=%0d exc=%0h exp 1/5/0", wb_valid, wb_rt, wb_exc); end
    checks++; if (wb_data !== ed) begin errors++; $display("FAIL single_n2_data got %0h exp %0h", wb_data, ed); end
    tick();
    #1;
    checks++; if (retired !== r0 + 1 || wb_valid !== 1'b0) begin errors++; $display("FAIL single_retired got %0d/%0h exp %0d/0", retired, wb_valid, r0 + 1); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] ed [8];
    logic [31:0]  r0;
    r0 = exp_retired; wb_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        in_valid = 1'b1; in_op = 4'($urandom_range(0, 14)); in_rt = 7'(k);
        in_ra = rnd128(); in_rb = rnd128(); in_imm = 10'($urandom);
        ed[k] = dp_fn(in_op, in_ra, in_rb, in_imm);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k < 8) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready k=%0d got %0h exp 1", k, in_ready); end
      end
      if (k >= 2) begin
        checks++; if (wb_valid !== 1'b1 || wb_rt !== 7'(k - 2) || wb_data !== ed[k-2]) begin
          errors++; $display("FAIL b2b_wb k=%0d got v=%0h rt=%0d data=%0h exp 1/%0d/%0h", k, wb_valid, wb_rt, wb_data, k - 2, ed[k-2]);
        end
      end
      tick();
    end
    #1;
    checks++; if (retired !== r0 + 8 || wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_retired got %0d v=%0h exp %0d/0", retired, wb_valid, r0 + 8); end
  endtask

  task automatic test_stall();
    logic [127:0] ed [3];
    logic [127:0] held;
    logic [31:0]  r0;
    r0 = exp_retired; wb_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_op = 4'($urandom_range(0, 14)); in_rt = 7'(10 + k);
      in_ra = rnd128(); in_rb = rnd128(); in_imm = 10'($urandom);
      ed[k] = dp_fn(in_op, in_ra, in_rb, in_imm);
      #1;
      if (k < 2) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_fill_ready k=%0d got %0h exp 1", k, in_ready); end
        tick();
      end
    end
    // Third op stays offered through two blocked cycles.
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || wb_valid !== 1'b1 || wb_rt !== 7'd10 || wb_data !== ed[0]) begin
        errors++; $display("FAIL stall_hold k=%0d got rdy=%0h v=%0h rt=%0d data=%0h exp 0/1/10/%0h", k, in_ready, wb_valid, wb_rt, wb_data, ed[0]);
      end
      held = wb_data;
      tick();
      #1;
      checks++; if (wb_data !== held) begin errors++; $display("FAIL stall_stable k=%0d got %0h exp %0h", k, wb_data, held); end
    end
    wb_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %0h exp 1", in_ready); end
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (wb_valid !== 1'b1 || wb_rt !== 7'(10 + k) || wb_data !== ed[k]) begin
        errors++; $display("FAIL stall_drain k=%0d got v=%0h rt=%0d data=%0h exp 1/%0d/%0h", k, wb_valid, wb_rt, wb_data, 10 + k, ed[k]);
      end
      tick();
      in_valid = 1'b0;
    end
    #1;
    checks++; if (wb_valid !== 1'b0 || retired !== r0 + 3) begin errors++; $display("FAIL stall_done got v=%0h ret=%0d exp 0/%0d", wb_valid, retired, r0 + 3); end
  endtask

  task automatic test_flush();
    logic [31:0] r0;
    r0 = exp_retired; wb_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_op = FX1_OR; in_rt = 7'(20 + k); in_ra = rnd128(); in_rb = rnd128();
      tick();
    end
    in_rt = 7'd22; flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0 || ex1_vld !== 1'b1 || ex2_vld !== 1'b1) begin errors++; $display("FAIL flush_pre got rdy=%0h ex1=%0h ex2=%0h exp 0/1/1", in_ready, ex1_vld, ex2_vld); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || wb_valid !== 1'b0 || ex1_vld !== 1'b0) begin errors++; $display("FAIL flush_clear got busy=%0h wb=%0h ex1=%0h exp 0", busy, wb_valid, ex1_vld); end
    checks++; if (retired !== r0) begin errors++; $display("FAIL flush_retired got %0d exp %0d", retired, r0); end
    tick(); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_dropped got busy=%0h exp 0", busy); end
    // Flush coinciding with an accepted writeback still retires that op.
    in_valid = 1'b1; in_rt = 7'd23; tick();
    in_valid = 1'b0; tick();
    flush = 1'b1; wb_ready = 1'b1;
    #1;
    checks++; if (wb_valid !== 1'b1 || wb_rt !== 7'd23) begin errors++; $display("FAIL flush_wb_pre got v=%0h rt=%0d exp 1/23", wb_valid, wb_rt); end
    tick();
    flush = 1'b0;
    #1;
    checks++; if (retired !== r0 + 1 || busy !== 1'b0) begin errors++; $display("FAIL flush_wb_count got ret=%0d busy=%0h exp %0d/0", retired, busy, r0 + 1); end
  endtask

  task automatic test_unsupported();
    logic [31:0] r0;
    r0 = exp_retired; wb_ready = 1'b1;
    in_valid = 1'b1; in_op = 4'hF; in_rt = 7'd9; in_ra = rnd128(); in_rb = rnd128(); in_imm = 10'h155;
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    checks++; if (wb_valid !== 1'b1 || wb_exc !== 1'b1 || wb_rt !== 7'd9) begin errors++; $display("FAIL unsup_wb got v=%0h exc=%0h rt=%0d exp 1/1/9", wb_valid, wb_exc, wb_rt); end
    checks++; if (wb_data !== 128'd0) begin errors++; $display("FAIL unsup_data got %0h exp 0", wb_data); end
    tick();
    #1;
    checks++; if (retired !== r0 + 1) begin errors++; $display("FAIL unsup_retired got %0d exp %0d", retired, r0 + 1); end
  endtask

  task automatic test_reset_mid();
    wb_ready = 1'b0;
    in_valid = 1'b1; in_op = FX1_XOR; in_rt = 7'd30; in_ra = rnd128(); in_rb = rnd128();
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre got v=%0h exp 1", wb_valid); end
    reset = 1'b1;
    tick();
    #1;
    checks++; if (wb_valid !== 1'b0 || ex1_vld !== 1'b0 || busy !== 1'b0 || retired !== 32'd0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rmid_reset got v=%0h ex1=%0h busy=%0h ret=%0d rdy=%0h exp 0", wb_valid, ex1_vld, busy, retired, in_ready);
    end
    reset = 1'b0; wb_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_release got %0h exp 1", in_ready); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_op    = 4'($urandom_range(0, 15));
      in_rt    = 7'($urandom);
      in_ra    = rnd128();
      in_rb    = rnd128();
      in_imm   = 10'($urandom);
      wb_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 29) == 0);
      #1;
      checks++; if (in_ready !== exp_in_ready()) begin errors++; $display("FAIL rnd_in_ready n=%0d got %0h exp %0h", n, in_ready, exp_in_ready()); end
      checks++; if (wb_valid !== exp_wb_valid()) begin errors++; $display("FAIL rnd_wb_valid n=%0d got %0h exp %0h", n, wb_valid, exp_wb_valid()); end
      if (exp_wb_valid()) begin
        checks++; if (wb_rt !== q[0].rt || wb_data !== q[0].data || wb_exc !== q[0].exc) begin
          errors++; $display("FAIL rnd_wb n=%0d got rt=%0d exc=%0h data=%0h exp %0d/%0h/%0h", n, wb_rt, wb_exc, wb_data, q[0].rt, q[0].exc, q[0].data);
        end
        checks++; if (ex2_rt !== q[0].rt) begin errors++; $display("FAIL rnd_ex2_rt n=%0d got %0d exp %0d", n, ex2_rt, q[0].rt); end
      end
      checks++; if (ex1_vld !== exp_ex1()) begin errors++; $display("FAIL rnd_ex1_vld n=%0d got %0h exp %0h", n, ex1_vld, exp_ex1()); end
      if (exp_ex1()) begin
        checks++; if (ex1_rt !== q[q.size()-1].rt) begin errors++; $display("FAIL rnd_ex1_rt n=%0d got %0d exp %0d", n, ex1_rt, q[q.size()-1].rt); end
      end
      checks++; if (busy !== (q.size() > 0)) begin errors++; $display("FAIL rnd_busy n=%0d got %0h exp %0h", n, busy, q.size() > 0); end
      checks++; if (retired !== exp_retired) begin errors++; $display("FAIL rnd_retired n=%0d got %0d exp %0d", n, retired, exp_retired); end
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; wb_ready = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_flush();
    test_unsupported();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
